// File: rtl/obi_pkg.sv
// OBI bus request/response types shared by masters, slaves and interconnect.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_rr_arbiter_pkg.sv
// Constants and helpers for the N-to-1 round-robin OBI arbiter.
package obi_rr_arbiter_pkg;

  localparam int OBI_ARB_DEFAULT_OUTSTANDING = 4;

  // Width of a master index; a single master still needs one bit.
  function automatic int obi_arb_idx_w(input int nmaster);
    return (nmaster > 1) ? $clog2(nmaster) : 1;
  endfunction

endpackage

// File: rtl/obi_rr_arbiter_fifo.sv
// Response-routing FIFO: remembers which master owns each issued transaction.
// Head is read combinationally so a response can be routed in the cycle it arrives.
module obi_rr_arbiter_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally at DEPTH (power of two); occupancy tracks push minus pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/obi_rr_arbiter.sv
// N-master to 1-slave OBI arbiter: round-robin grant, request lock while the
// slave stalls, in-order response routing through an index FIFO.
// Optional macro OBI_RR_ARBITER_ERR_EN: sticky err_o on responses with nothing outstanding.
module obi_rr_arbiter
  import obi_pkg::*;
  import obi_rr_arbiter_pkg::*;
#(
  parameter int NMASTER         = 5,
  parameter int MAX_OUTSTANDING = OBI_ARB_DEFAULT_OUTSTANDING,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  obi_req_t  [NMASTER-1:0]  master_req_i,
  output obi_resp_t [NMASTER-1:0]  master_resp_o,
  output obi_req_t                 slave_req_o,
  input  obi_resp_t                slave_resp_i,
  output logic [CNT_W-1:0]         outstanding_o,
  output logic                     err_o
);

  localparam int IDX_W = obi_arb_idx_w(NMASTER);

  logic [IDX_W-1:0] rr_ptr_q;
  logic             lock_q;
  logic [IDX_W-1:0] lock_idx_q;
  logic [IDX_W-1:0] cand_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] head_idx;
  logic             fifo_full;
  logic             fifo_empty;
  logic             handshake;
  logic             pop;

  // Round-robin candidate: first requester scanning upward from rr_ptr_q.
  always_comb begin
    int  idx;
    logic found;
    cand_idx = rr_ptr_q;
    found    = 1'b0;
    for (int k = 0; k < NMASTER; k++) begin
      idx = (int'(rr_ptr_q) + k) % NMASTER;
      if (!found && master_req_i[idx].req) begin
        found    = 1'b1;
        cand_idx = IDX_W'(idx);
      end
    end
  end

  // A stalled request keeps the slave port so address/data stay stable until granted.
  assign sel_idx = lock_q ? lock_idx_q : cand_idx;

  // Forward the selected master; nothing is issued while the routing FIFO is full.
  always_comb begin
    slave_req_o     = master_req_i[sel_idx];
    slave_req_o.req = master_req_i[sel_idx].req & ~fifo_full;
  end

  assign handshake = slave_req_o.req & slave_resp_i.gnt;
  assign pop       = slave_resp_i.rvalid & ~fifo_empty;
  assign next_ptr  = (int'(sel_idx) == NMASTER - 1) ? '0 : sel_idx + 1'b1;

  // Pointer advances past the winner on each handshake; lock holds across slave stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      if (handshake) rr_ptr_q <= next_ptr;
      lock_q <= slave_req_o.req & ~slave_resp_i.gnt;
      if (slave_req_o.req & ~slave_resp_i.gnt) lock_idx_q <= sel_idx;
    end
  end

  obi_rr_arbiter_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake),
    .data_i  (sel_idx),
    .pop_i   (pop),
    .data_o  (head_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

  // Per-master response: grant to the forwarded master, rvalid to the FIFO head, rdata broadcast.
  for (genvar gi = 0; gi < NMASTER; gi++) begin : g_resp
    assign master_resp_o[gi] = '{
      gnt:    handshake && (sel_idx == IDX_W'(gi)),
      rvalid: pop && (head_idx == IDX_W'(gi)),
      rdata:  slave_resp_i.rdata
    };
  end

`ifdef OBI_RR_ARBITER_ERR_EN
  logic err_q;

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                     err_q <= 1'b0;
    else if (slave_resp_i.rvalid && fifo_empty)    err_q <= 1'b1;
  end

  assign err_o = err_q;

  spurious_rvalid_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(slave_resp_i.rvalid && fifo_empty));
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed bench for obi_rr_arbiter (NMASTER=5, MAX_OUTSTANDING=4).
module tb_obi_rr_arbiter;
  import obi_pkg::*;

  localparam int NMASTER = 5;
`ifdef OBI_RR_ARBITER_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  obi_req_t  [NMASTER-1:0] mreq;
  obi_resp_t [NMASTER-1:0] mresp;
  obi_req_t  sreq;
  obi_resp_t sresp;
  logic [2:0] outstanding;
  logic       err;
  logic [NMASTER-1:0] gnt_vec;
  logic [NMASTER-1:0] rvalid_vec;

  int checks = 0;
  int errors = 0;

  obi_rr_arbiter #(.NMASTER(NMASTER), .MAX_OUTSTANDING(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .master_req_i  (mreq),
    .master_resp_o (mresp),
    .slave_req_o   (sreq),
    .slave_resp_i  (sresp),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    gnt_vec    = '0;
    rvalid_vec = '0;
    for (int i = 0; i < NMASTER; i++) begin
      gnt_vec[i]    = mresp[i].gnt;
      rvalid_vec[i] = mresp[i].rvalid;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mreq  = '0;
    sresp = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    checks++;
    if (outstanding !== 3'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: outstanding=%0d err=%b, want 0 0", outstanding, err);
    end
    checks++;
    if (gnt_vec !== '0 || rvalid_vec !== '0 || sreq.req !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b rvalid=%b sreq=%b, want 0 0 0", gnt_vec, rvalid_vec, sreq.req);
    end
    checks++;
    if (dut.rr_ptr_q !== 3'd0 || dut.lock_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_ptr: rr_ptr=%0d lock=%b, want 0 0", dut.rr_ptr_q, dut.lock_q);
    end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    int peak;
    logic [31:0] exp_rdata;
    peak = 0;
    do_reset();
    sresp.gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mreq[0].req  = (i < 3);
      mreq[0].addr = 32'h100 + 32'(4 * i);
      sresp.rvalid = (i > 0);
      exp_rdata    = 32'hA + 32'(i) - 32'd1;
      sresp.rdata  = (i > 0) ? exp_rdata : 32'h0;
      #1;
      checks++;
      if (gnt_vec !== ((i < 3) ? 5'b00001 : 5'b00000)) begin
        errors++;
        $display("FAIL single_gnt[%0d]: got %b", i, gnt_vec);
      end
      if (i < 3) begin
        checks++;
        if (sreq.addr !== 32'h100 + 32'(4 * i)) begin
          errors++;
          $display("FAIL single_addr[%0d]: got %h want %h", i, sreq.addr, 32'h100 + 32'(4 * i));
        end
      end
      if (i > 0) begin
        checks++;
        if (rvalid_vec !== 5'b00001 || mresp[0].rdata !== exp_rdata) begin
          errors++;
          $display("FAIL single_resp[%0d]: rvalid=%b rdata=%h want 00001 %h", i, rvalid_vec, mresp[0].rdata, exp_rdata);
        end
      end
      if (int'(outstanding) > peak) peak = int'(outstanding);
      $display("single txn %0d: gnt=%b rvalid=%b rdata=%h outstanding=%0d", i, gnt_vec, rvalid_vec, mresp[0].rdata, outstanding);
      cyc();
    end
    clear_inputs();
    #1;
    checks++;
    if (peak !== 1 || outstanding !== 3'd0) begin
      errors++;
      $display("FAIL single_outstanding: peak=%0d final=%0d want 1 0", peak, outstanding);
    end
  endtask

  task automatic test_round_robin();
    int exp_order [6] = '{0, 2, 4, 0, 2, 4};
    do_reset();
    sresp.gnt = 1'b1;
    for (int i = 0; i < 7; i++) begin
      mreq[0].req = (i < 6);
      mreq[2].req = (i < 6);
      mreq[4].req = (i < 6);
      sresp.rvalid = (i > 0);
      sresp.rdata  = 32'h500 + 32'(i);
      #1;
      checks++;
      if (gnt_vec !== ((i < 6) ? 5'(1 << exp_order[i]) : 5'b0)) begin
        errors++;
        $display("FAIL rr_gnt[%0d]: got %b", i, gnt_vec);
      end
      if (i > 0) begin
        checks++;
        if (rvalid_vec !== 5'(1 << exp_order[i-1])) begin
          errors++;
          $display("FAIL rr_rvalid[%0d]: got %b want %b", i, rvalid_vec, 5'(1 << exp_order[i-1]));
        end
      end
      if (i == 1) begin
        checks++;
        if (dut.rr_ptr_q !== 3'd1) begin
          errors++;
          $display("FAIL rr_ptr_after_first: got %0d want 1", dut.rr_ptr_q);
        end
      end
      $display("rr txn %0d: gnt=%b rvalid=%b", i, gnt_vec, rvalid_vec);
      cyc();
    end
    clear_inputs();
    #1;
    checks++;
    if (outstanding !== 3'd0) begin
      errors++;
      $display("FAIL rr_drain: outstanding=%0d want 0", outstanding);
    end
  endtask

  task automatic test_lock();
    do_reset();
    mreq[1].addr = 32'h1111_0000;
    mreq[0].addr = 32'h0000_0AA0;
    for (int i = 0; i < 7; i++) begin
      mreq[1].req  = (i < 4);
      mreq[0].req  = (i >= 2 && i < 5);
      sresp.gnt    = (i == 3 || i == 4);
      sresp.rvalid = (i >= 5);
      sresp.rdata  = 32'(i);
      #1;
      if (i < 3) begin
        checks++;
        if (sreq.req !== 1'b1 || sreq.addr !== 32'h1111_0000 || gnt_vec !== 5'b0) begin
          errors++;
          $display("FAIL lock_hold[%0d]: req=%b addr=%h gnt=%b want 1 11110000 00000", i, sreq.req, sreq.addr, gnt_vec);
        end
      end
      if (i == 3) begin
        checks++;
        if (gnt_vec !== 5'b00010) begin
          errors++;
          $display("FAIL lock_release: gnt=%b want 00010", gnt_vec);
        end
      end
      if (i == 4) begin
        checks++;
        if (gnt_vec !== 5'b00001 || sreq.addr !== 32'h0000_0AA0) begin
          errors++;
          $display("FAIL lock_next: gnt=%b addr=%h want 00001 00000aa0", gnt_vec, sreq.addr);
        end
      end
      if (i >= 5) begin
        checks++;
        if (rvalid_vec !== ((i == 5) ? 5'b00010 : 5'b00001)) begin
          errors++;
          $display("FAIL lock_resp[%0d]: rvalid=%b", i, rvalid_vec);
        end
      end
      $display("lock txn %0d: sreq=%b addr=%h gnt=%b rvalid=%b", i, sreq.req, sreq.addr, gnt_vec, rvalid_vec);
      cyc();
    end
    clear_inputs();
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      mreq[2].req  = 1'b1;
      mreq[2].addr = 32'h200 + 32'(4 * i);
      sresp.gnt    = 1'b1;
      sresp.rvalid = (i == 5);
      sresp.rdata  = 32'h55;
      #1;
      if (i < 4) begin
        checks++;
        if (gnt_vec !== 5'b00100 || sreq.req !== 1'b1) begin
          errors++;
          $display("FAIL full_fill[%0d]: gnt=%b req=%b", i, gnt_vec, sreq.req);
        end
      end else if (i < 6) begin
        checks++;
        if (sreq.req !== 1'b0 || gnt_vec !== 5'b0 || outstanding !== 3'd4) begin
          errors++;
          $display("FAIL full_stall[%0d]: req=%b gnt=%b outstanding=%0d want 0 0 4", i, sreq.req, gnt_vec, outstanding);
        end
      end else begin
        checks++;
        if (sreq.req !== 1'b1 || gnt_vec !== 5'b00100 || outstanding !== 3'd3) begin
          errors++;
          $display("FAIL full_resume: req=%b gnt=%b outstanding=%0d want 1 00100 3", sreq.req, gnt_vec, outstanding);
        end
      end
      if (i == 5) begin
        checks++;
        if (rvalid_vec !== 5'b00100) begin
          errors++;
          $display("FAIL full_pop: rvalid=%b want 00100", rvalid_vec);
        end
      end
      $display("full txn %0d: sreq=%b gnt=%b rvalid=%b outstanding=%0d", i, sreq.req, gnt_vec, rvalid_vec, outstanding);
      cyc();
    end
    clear_inputs();
    sresp.rvalid = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    sresp.rvalid = 1'b0;
    #1;
    checks++;
    if (outstanding !== 3'd0) begin
      errors++;
      $display("FAIL full_drain: outstanding=%0d want 0", outstanding);
    end
  endtask

  task automatic test_interleave();
    logic [4:0] exp_rv;
    logic [31:0] exp_rd;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mreq[3].req  = (i == 0);
      mreq[1].req  = (i == 1);
      sresp.gnt    = 1'b1;
      sresp.rvalid = (i >= 2);
      exp_rd       = (i == 2) ? 32'h33 : 32'h11;
      sresp.rdata  = exp_rd;
      #1;
      if (i < 2) begin
        checks++;
        if (gnt_vec !== ((i == 0) ? 5'b01000 : 5'b00010)) begin
          errors++;
          $display("FAIL inter_gnt[%0d]: gnt=%b", i, gnt_vec);
        end
      end else begin
        exp_rv = (i == 2) ? 5'b01000 : 5'b00010;
        checks++;
        if (rvalid_vec !== exp_rv || mresp[(i == 2) ? 3 : 1].rdata !== exp_rd) begin
          errors++;
          $display("FAIL inter_resp[%0d]: rvalid=%b rdata=%h want %b %h", i, rvalid_vec, mresp[(i == 2) ? 3 : 1].rdata, exp_rv, exp_rd);
        end
      end
      $display("interleave txn %0d: gnt=%b rvalid=%b rdata=%h", i, gnt_vec, rvalid_vec, sresp.rdata);
      cyc();
    end
    clear_inputs();
  endtask

  task automatic test_spurious();
    do_reset();
    sresp.rvalid = 1'b1;
    sresp.rdata  = 32'hDEAD;
    #1;
    checks++;
    if (rvalid_vec !== 5'b0) begin
      errors++;
      $display("FAIL spur_drop: rvalid=%b want 00000", rvalid_vec);
    end
    cyc();
    sresp.rvalid = 1'b0;
    #1;
    checks++;
    if (err !== ERR_EN) begin
      errors++;
      $display("FAIL spur_err: err=%b want %b", err, ERR_EN);
    end
    cyc();
    checks++;
    if (err !== ERR_EN) begin
      errors++;
      $display("FAIL spur_sticky: err=%b want %b", err, ERR_EN);
    end
    mreq[0].req = 1'b1;
    sresp.gnt   = 1'b1;
    cyc();
    clear_inputs();
    #1;
    checks++;
    if (outstanding !== 3'd1) begin
      errors++;
      $display("FAIL spur_issue: outstanding=%0d want 1", outstanding);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (outstanding !== 3'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL spur_async_rst: outstanding=%0d err=%b want 0 0", outstanding, err);
    end
    cyc();
    rst = 1'b0;
    sresp.rvalid = 1'b1;
    sresp.rdata  = 32'hBEEF;
    #1;
    checks++;
    if (rvalid_vec !== 5'b0) begin
      errors++;
      $display("FAIL spur_late_resp: rvalid=%b want 00000", rvalid_vec);
    end
    $display("spurious txn: err=%b rvalid=%b outstanding=%0d", err, rvalid_vec, outstanding);
    cyc();
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_full();
    test_interleave();
    test_spurious();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
